// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset handshake between the PLL-side logic and the reset sequencer.
// The sequencer uses the slave modport; the system side uses master.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       soft_reset;
    logic       rst_periph;
    logic       rst_core;
    logic       ready;
    logic [7:0] loss_count;

    modport master (
        output pll_locked,
        output soft_reset,
        input  rst_periph,
        input  rst_core,
        input  ready,
        input  loss_count
    );

    modport slave (
        input  pll_locked,
        input  soft_reset,
        output rst_periph,
        output rst_core,
        output ready,
        output loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then releases staged synchronous resets: peripherals first, core later.
// Re-asserts both resets on lock loss and keeps a saturating count of losses seen in RUN.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    pll_reset_sequencer_if.slave   bus
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   rst_periph_q;
    logic                   rst_core_q;
    logic                   ready_q;
    logic [7:0]             loss_count_q;

    // pll_locked is asynchronous to clock; only the last synchroniser stage is ever used.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value (a true shift).
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_LOCK;
            count        <= '0;
            rst_periph_q <= 1'b1;
            rst_core_q   <= 1'b1;
            ready_q      <= 1'b0;
            loss_count_q <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        count <= '0;
                    end
                end

                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        count <= '0;
                    end else if (count == STABLE_LAST) begin
                        state        <= RELEASE;
                        count        <= '0;
                        rst_periph_q <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                RELEASE: begin
                    if (!locked_s) begin
                        state        <= WAIT_LOCK;
                        count        <= '0;
                        rst_periph_q <= 1'b1;
                    end else if (count == HOLD_LAST) begin
                        state      <= RUN;
                        count      <= '0;
                        rst_core_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                RUN: begin
                    // Lock loss outranks a simultaneous soft_reset.
                    if (!locked_s) begin
                        state        <= WAIT_LOCK;
                        count        <= '0;
                        rst_periph_q <= 1'b1;
                        rst_core_q   <= 1'b1;
                        ready_q      <= 1'b0;
                        if (loss_count_q != 8'hFF) begin
                            loss_count_q <= loss_count_q + 8'd1;
                        end
                    end else if (bus.soft_reset) begin
                        state        <= STABLE;
                        count        <= '0;
                        rst_periph_q <= 1'b1;
                        rst_core_q   <= 1'b1;
                        ready_q      <= 1'b0;
                    end
                end

                default: begin
                    state        <= WAIT_LOCK;
                    count        <= '0;
                    rst_periph_q <= 1'b1;
                    rst_core_q   <= 1'b1;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_periph = rst_periph_q;
    assign bus.rst_core   = rst_core_q;
    assign bus.ready      = ready_q;
    assign bus.loss_count = loss_count_q;

    // The core must never leave reset while peripherals are still held.
    a_core_after_periph: assert property (@(posedge clock) disable iff (!reset_n)
        rst_periph_q |-> rst_core_q);

    a_ready_tracks_core: assert property (@(posedge clock) disable iff (!reset_n)
        ready_q == !rst_core_q);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output snapshots are queued
// against absolute edge numbers when stimulus is driven and compared as those edges pass.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;

    typedef struct {
        int    at_cyc;
        logic  periph;
        logic  core;
        logic  rdy;
        int    loss;
        string tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    exp_t sb[$];
    exp_t mon_item;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (STABLE),
        .HOLD_CYCLES        (HOLD)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Each negedge sits between edges; cyc then equals the number of edges seen so far.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            mon_item = sb.pop_front();
            chk_cnt++;
            if (bus.rst_periph !== mon_item.periph || bus.rst_core !== mon_item.core ||
                bus.ready !== mon_item.rdy ||
                (mon_item.loss >= 0 && bus.loss_count !== 8'(mon_item.loss))) begin
                $display("FAIL %s edge %0d (now %0d): got periph=%b core=%b ready=%b loss=%0d, want periph=%b core=%b ready=%b loss=%0d",
                         mon_item.tag, mon_item.at_cyc, cyc, bus.rst_periph, bus.rst_core, bus.ready,
                         bus.loss_count, mon_item.periph, mon_item.core, mon_item.rdy, mon_item.loss);
            end else begin
                pass_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int at, input logic p, input logic c, input logic r,
                        input int loss, input string tag);
        exp_t item;
        item.at_cyc = at;
        item.periph = p;
        item.core   = c;
        item.rdy    = r;
        item.loss   = loss;
        item.tag    = tag;
        sb.push_back(item);
    endtask

    // b is the absolute number of the edge that first samples pll_locked high.
    task automatic expect_sequence(input int b, input int loss, input string tag);
        push(b + SYNC + STABLE - 1,        1'b1, 1'b1, 1'b0, loss, {tag, "_periph_held"});
        push(b + SYNC + STABLE,            1'b0, 1'b1, 1'b0, loss, {tag, "_periph_fall"});
        push(b + SYNC + STABLE + HOLD - 1, 1'b0, 1'b1, 1'b0, loss, {tag, "_core_held"});
        push(b + SYNC + STABLE + HOLD,     1'b0, 1'b0, 1'b1, loss, {tag, "_core_fall"});
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step(1);
            n++;
        end
        if (sb.size() > 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_timeout: %0d entries pending, first %s at edge %0d, now %0d",
                     sb.size(), sb[0].tag, sb[0].at_cyc, cyc);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b0;
        step(3);
        chk_cnt++;
        if (bus.rst_periph !== 1'b1) $display("FAIL reset_periph: got %b want 1", bus.rst_periph);
        else pass_cnt++;
        chk_cnt++;
        if (bus.rst_core !== 1'b1) $display("FAIL reset_core: got %b want 1", bus.rst_core);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready);
        else pass_cnt++;
        chk_cnt++;
        if (bus.loss_count !== 8'd0) $display("FAIL reset_loss: got %0d want 0", bus.loss_count);
        else pass_cnt++;
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_startup();
        bus.pll_locked = 1'b1;
        expect_sequence(cyc + 1, 0, "startup");
        wait_drained(40);
    endtask

    task automatic test_lock_loss();
        int e;
        bus.pll_locked = 1'b0;
        e = cyc + 1;
        push(e + SYNC - 1, 1'b0, 1'b0, 1'b1, 0, "loss_still_run");
        push(e + SYNC,     1'b1, 1'b1, 1'b0, 1, "loss_assert");
        wait_drained(10);
        step(2);
        bus.pll_locked = 1'b1;
        expect_sequence(cyc + 1, 1, "relock");
        wait_drained(40);
    endtask

    task automatic test_stable_glitch();
        int e;
        int b;
        bus.pll_locked = 1'b0;
        e = cyc + 1;
        push(e + SYNC, 1'b1, 1'b1, 1'b0, 2, "glitch_prep_loss");
        wait_drained(10);
        step(2);
        bus.pll_locked = 1'b1;
        b = cyc + 1;
        // FSM sees the dropout when the STABLE counter holds 5.
        while (cyc < b + 5) step(1);
        bus.pll_locked = 1'b0;
        step(3);
        bus.pll_locked = 1'b1;
        push(b + SYNC + STABLE, 1'b1, 1'b1, 1'b0, 2, "glitch_no_early_release");
        expect_sequence(cyc + 1, 2, "glitch_relock");
        wait_drained(60);
    endtask

    task automatic test_soft_reset();
        int s;
        bus.soft_reset = 1'b1;
        s = cyc + 1;
        push(s,                     1'b1, 1'b1, 1'b0, 2, "soft_assert");
        push(s + STABLE - 1,        1'b1, 1'b1, 1'b0, 2, "soft_periph_held");
        push(s + STABLE,            1'b0, 1'b1, 1'b0, 2, "soft_periph_fall");
        push(s + STABLE + HOLD - 1, 1'b0, 1'b1, 1'b0, 2, "soft_in_release_ignored");
        push(s + STABLE + HOLD,     1'b0, 1'b0, 1'b1, 2, "soft_core_fall");
        step(1);
        bus.soft_reset = 1'b0;
        while (cyc < s + STABLE + 1) step(1);
        bus.soft_reset = 1'b1;
        step(1);
        bus.soft_reset = 1'b0;
        wait_drained(30);
    endtask

    task automatic test_async_reset();
        int s;
        bus.soft_reset = 1'b1;
        s = cyc + 1;
        step(1);
        bus.soft_reset = 1'b0;
        while (cyc < s + STABLE + 1) step(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.rst_periph !== 1'b1) $display("FAIL async_periph: got %b want 1", bus.rst_periph);
        else pass_cnt++;
        chk_cnt++;
        if (bus.rst_core !== 1'b1) $display("FAIL async_core: got %b want 1", bus.rst_core);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ready !== 1'b0) $display("FAIL async_ready: got %b want 0", bus.ready);
        else pass_cnt++;
        chk_cnt++;
        if (bus.loss_count !== 8'd0) $display("FAIL async_loss: got %0d want 0", bus.loss_count);
        else pass_cnt++;
        step(2);
        reset_n = 1'b1;
        expect_sequence(cyc + 1, 0, "post_reset");
        wait_drained(40);
    endtask

    task automatic test_saturation();
        int e;
        int n;
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b0;
            e = cyc + 1;
            push(e + SYNC, 1'b1, 1'b1, 1'b0, (i + 1 > 255) ? 255 : i + 1, "sat_loss");
            if (i == 0) begin
                // soft_reset lands on the same edge that first sees locked_s low.
                while (cyc < e + SYNC - 1) step(1);
                bus.soft_reset = 1'b1;
                step(1);
                bus.soft_reset = 1'b0;
            end
            wait_drained(10);
            step(1);
            bus.pll_locked = 1'b1;
            n = 0;
            while (bus.ready !== 1'b1 && n < 40) begin
                step(1);
                n++;
            end
            chk_cnt++;
            if (bus.ready !== 1'b1) $display("FAIL sat_relock_%0d: ready=%b after %0d cycles, want 1", i, bus.ready, n);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bus.loss_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", bus.loss_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_lock_loss();
        test_stable_glitch();
        test_soft_reset();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the board PLL wrapper. It runs on the PLL output clock and consumes the PLL's asynchronous locked signal. It qualifies lock stability, then releases two staged, glitch-free, synchronously-deasserted resets to the design: peripherals first, core later. On loss of lock it re-asserts both resets and counts the event.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on pll_locked; must be at least 2.
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before releasing rst_periph; must be at least 1.
HOLD_CYCLES, 16, cycles between rst_periph deassert and rst_core deassert; must be at least 1.

Ports:
clock  input  1  PLL output clock; the only clock.
reset_n  input  1  asynchronous, active-low reset (e.g. board key or power-on).
pll_locked  input  1  PLL locked flag, asynchronous to clock.
soft_reset  input  1  synchronous, active-high request to re-run the sequence; sampled only in RUN.
rst_periph  output  1  active-high reset for peripherals; registered.
rst_core  output  1  active-high reset for the core; registered.
ready  output  1  high exactly when rst_core is low; registered.
loss_count  output  8  saturating count of lock losses seen while in RUN.

Behaviour:
- Reset state (reset_n low, asynchronously and at any time, including mid-sequence):
  - state = WAIT_LOCK; all synchroniser flops = 0; counter = 0.
  - rst_periph = 1, rst_core = 1, ready = 0, loss_count = 0.
- Release of reset_n takes effect at the next clock edge. No asynchronous deassert path exists.
- locked_s is pll_locked passed through SYNC_STAGES flops. It is the only lock signal the FSM uses.
- Counter width is clog2(max(LOCK_STABLE_CYCLES, HOLD_CYCLES)) + 1. The counter is cleared on every state change.
- States and transitions:
  - WAIT_LOCK: if locked_s = 1, go to STABLE with counter = 0.
  - STABLE:
    - if locked_s = 0, go to WAIT_LOCK;
    - else if counter == LOCK_STABLE_CYCLES-1, go to RELEASE;
    - else counter++.
  - RELEASE:
    - if locked_s = 0, go to WAIT_LOCK;
    - else if counter == HOLD_CYCLES-1, go to RUN;
    - else counter++.
  - RUN:
    - if locked_s = 0, go to WAIT_LOCK and loss_count++ (saturate at 255);
    - else if soft_reset = 1, go to STABLE with counter = 0.
- Outputs are flops updated on the same edge as the state register. They never come from a combinational decode.
  - rst_periph = 0 only in RELEASE and RUN.
  - rst_core = 0 only in RUN.
  - ready = !rst_core.
- Latency, taking edge 0 as the first edge that samples pll_locked high:
  - locked_s is high after edge SYNC_STAGES-1; the FSM enters STABLE at edge SYNC_STAGES.
  - rst_periph falls at edge SYNC_STAGES+LOCK_STABLE_CYCLES.
  - rst_core and ready change HOLD_CYCLES edges after that.
- Lock loss: if pll_locked falls before edge e, both resets are asserted at edge e+SYNC_STAGES. A lock glitch shorter than one cycle may be missed; this is acceptable.
- Loss in STABLE or RELEASE restarts qualification and does not increment loss_count.
- Simultaneous lock loss and soft_reset in RUN: lock loss wins (WAIT_LOCK, count increments).
- soft_reset outside RUN is ignored. soft_reset never increments loss_count.
- When pll_locked is held high, rst_periph and rst_core are monotonic with no glitches.

Test Plan:
- Parameters SYNC=2, STABLE=8, HOLD=4. Hold reset_n low, then release; raise pll_locked so edge 0 samples it high. Required: rst_periph falls at edge 10; rst_core falls and ready rises at edge 14; loss_count = 0.
- From RUN, drop pll_locked before edge e. Required: rst_periph = rst_core = 1 at edge e+2; loss_count = 1. Re-raise lock: the full 8+4 sequence repeats.
- pll_locked drops for 3 cycles during STABLE (counter at 5). Required: return to WAIT_LOCK; counter restarts from 0 after relock; rst_periph falls 10 edges after relock sampling; loss_count unchanged.
- soft_reset pulsed 1 cycle in RUN. Required: rst_periph and rst_core = 1 on the next edge; rst_periph deasserts 8 edges later and rst_core 4 after that; loss_count unchanged. A soft_reset pulse during RELEASE has no effect.
- Assert reset_n low mid-RELEASE, between clock edges. Required: outputs go to 1/1/0 and loss_count to 0 immediately, without waiting for an edge. After release, the sequence restarts from WAIT_LOCK.
- Force 300 lock losses from RUN. Required: loss_count saturates at 255 and does not wrap. Also issue soft_reset in the same cycle that locked_s falls: required WAIT_LOCK with count incremented.
